// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, drains received bytes and round-robins two TX requesters.
// Optional feature macro SPART_DRV_ECHO_EN: every received byte is echoed back out ahead of req0/req1.
module spart_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready
);
    typedef enum logic [2:0] {INIT_DBL, INIT_DBH, IDLE, RD_RX, WR_TX, TX_HOLD} state_t;

    localparam logic [1:0] SEL_REQ0 = 2'd0;
    localparam logic [1:0] SEL_REQ1 = 2'd1;
    localparam logic [1:0] SEL_ECHO = 2'd2;

    state_t     state, state_nxt;
    logic [1:0] prog_cfg, cfg_lat;
    logic [1:0] sel, sel_nxt;
    logic       rr_ptr;
    logic [7:0] wdata;
    logic       echo_pending;
    logic [7:0] echo_byte;
    logic       tx_pending;

    // 50 MHz clock, 16x oversampling.
    function automatic logic [7:0] div_byte(input logic [1:0] cfg, input logic hi);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = 16'd650;
            2'b01:   d = 16'd325;
            2'b10:   d = 16'd162;
            default: d = 16'd80;
        endcase
        div_byte = hi ? d[15:8] : d[7:0];
    endfunction

`ifdef SPART_DRV_ECHO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_pending <= 1'b0;
            echo_byte    <= 8'h00;
        end else if (state == RD_RX) begin
            echo_pending <= 1'b1;
            echo_byte    <= databus;
        end else if (state == WR_TX && sel == SEL_ECHO) begin
            echo_pending <= 1'b0;
        end
    end
`else
    assign echo_pending = 1'b0;
    assign echo_byte    = 8'h00;
`endif

    assign tx_pending = echo_pending | req0_valid | req1_valid;

    // rr_ptr=0 means req0 wins a tie; an echo never moves the pointer.
    always_comb begin
        if (echo_pending)                   sel_nxt = SEL_ECHO;
        else if (req0_valid && req1_valid)  sel_nxt = rr_ptr ? SEL_REQ1 : SEL_REQ0;
        else if (req1_valid)                sel_nxt = SEL_REQ1;
        else                                sel_nxt = SEL_REQ0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT_DBL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_DBL: state_nxt = INIT_DBH;
            INIT_DBH: state_nxt = IDLE;
            IDLE: begin
                if (br_cfg != prog_cfg)                        state_nxt = INIT_DBL;
                else if (rda && !rx_valid && !echo_pending)    state_nxt = RD_RX;
                else if (tbr && tx_pending)                    state_nxt = WR_TX;
            end
            RD_RX:    state_nxt = IDLE;
            WR_TX:    state_nxt = TX_HOLD;
            TX_HOLD:  state_nxt = IDLE;
            default:  state_nxt = INIT_DBL;
        endcase
    end

    // Gating on rst kills an in-flight access the moment reset asserts.
    always_comb begin
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = 2'b00;
        wdata      = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            case (state)
                INIT_DBL: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    wdata  = div_byte(br_cfg, 1'b0);
                end
                INIT_DBH: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    wdata  = div_byte(cfg_lat, 1'b1);
                end
                RD_RX: iocs = 1'b1;
                WR_TX: begin
                    iocs = 1'b1;
                    iorw = 1'b0;
                    case (sel)
                        SEL_REQ1: begin wdata = req1_data; req1_ready = 1'b1; end
                        SEL_ECHO: wdata = echo_byte;
                        default:  begin wdata = req0_data; req0_ready = 1'b1; end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign databus = (iocs && !iorw) ? wdata : 8'hzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_cfg <= 2'b00;
            cfg_lat  <= 2'b00;
            rr_ptr   <= 1'b0;
            sel      <= SEL_REQ0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            case (state)
                INIT_DBL: cfg_lat  <= br_cfg;
                INIT_DBH: prog_cfg <= cfg_lat;
                IDLE:     sel      <= sel_nxt;
                WR_TX: begin
                    if (sel == SEL_REQ0)      rr_ptr <= 1'b1;
                    else if (sel == SEL_REQ1) rr_ptr <= 1'b0;
                end
                default: ;
            endcase
            if (state == RD_RX) begin
                rx_valid <= 1'b1;
                rx_data  <= databus;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed scenarios plus randomized traffic against a transaction-level SPART/requester model.
module tb_spart_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda, tbr;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] spart_rd;

    spart_driver dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req1_valid(req1_valid), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
    );

    assign databus = (iocs && iorw) ? spart_rd : 8'hzz;

    always #5 clk = ~clk;

    logic [15:0] div_tab [4] = '{16'd650, 16'd325, 16'd162, 16'd80};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: reference model of what the bus must carry.
    logic [7:0] rxq[$];
    logic [7:0] echoq[$];
    int         last_gnt = 1;
    int         exp_gnt;
    logic [1:0] init_cfg = 2'b00;
    logic       tbr_prev = 1'b0, v0_prev = 1'b0, v1_prev = 1'b0;
    logic       seen_acc0 = 1'b0, seen_acc1 = 1'b0, seen_rd = 1'b0, seen_tx = 1'b0;
    int         tx_count = 0, rd_count = 0;

    always @(negedge clk) begin
        seen_acc0 = req0_ready;
        seen_acc1 = req1_ready;
        seen_rd   = iocs && iorw;
        seen_tx   = iocs && !iorw && ioaddr == 2'b00;
        if (rst) begin
            rxq.delete();
            echoq.delete();
            last_gnt = 1;
        end else begin
            if (iocs && !iorw && ioaddr == 2'b10) begin
                check("div_lo", databus, div_tab[br_cfg][7:0]);
                init_cfg = br_cfg;
            end
            if (iocs && !iorw && ioaddr == 2'b11)
                check("div_hi", databus, div_tab[init_cfg][15:8]);
            if (seen_tx) begin
                tx_count++;
                check("tx_after_tbr", tbr_prev, 1);
                if (echoq.size() > 0) begin
                    check("echo_data", databus, echoq[0]);
                    check("echo_no_ready", {req1_ready, req0_ready}, 0);
                    void'(echoq.pop_front());
                end else begin
                    check("tx_has_req", v0_prev | v1_prev, 1);
                    exp_gnt = (v0_prev && v1_prev) ? 1 - last_gnt : (v1_prev ? 1 : 0);
                    check("gnt_ready", {req1_ready, req0_ready}, (exp_gnt == 1) ? 2'b10 : 2'b01);
                    check("tx_data", databus, (exp_gnt == 1) ? req1_data : req0_data);
                    last_gnt = exp_gnt;
                end
            end else begin
                check("ready_outside_wr", {req1_ready, req0_ready}, 0);
            end
            if (seen_rd) begin
                rd_count++;
                check("rd_addr", ioaddr, 0);
                check("rd_while_held", rx_valid, 0);
                check("rd_while_echo", echoq.size(), 0);
                rxq.push_back(spart_rd);
`ifdef SPART_DRV_ECHO_EN
                echoq.push_back(spart_rd);
`endif
            end
            if (rx_valid) begin
                if (rxq.size() == 0) check("rx_spurious", rx_valid, 0);
                else begin
                    check("rx_data", rx_data, rxq[0]);
                    if (rx_ready) void'(rxq.pop_front());
                end
            end
        end
        tbr_prev = tbr;
        v0_prev  = req0_valid;
        v1_prev  = req1_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_init(input string tag, input logic [1:0] cfg, input int lat);
        int n = 0;
        @(negedge clk);
        while (!(iocs && !iorw && ioaddr == 2'b10) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_lo"}, databus, div_tab[cfg][7:0]);
        @(negedge clk);
        check({tag, "_hi_bus"}, {iocs, iorw, ioaddr}, 4'b1011);
        check({tag, "_hi"}, databus, div_tab[cfg][15:8]);
        @(negedge clk);
        check({tag, "_idle"}, iocs, 0);
    endtask

    logic [7:0] wd [3];
    int         wt [3];
    int         n, k, tbr_wait;

    initial begin
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_ready = 1'b0; spart_rd = 8'h00;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        tbr_wait = 0;
        repeat (3) @(negedge clk);
        check("rst_iocs", iocs, 0);
        check("rst_iorw", iorw, 1);
        check("rst_ioaddr", ioaddr, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_init("init01", 2'b01, 0);

        step(); br_cfg = 2'b11;
        expect_init("cfg11", 2'b11, 1);

        step(); tbr = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hA0; req1_valid = 1'b1; req1_data = 8'hB1;
        n = 0; k = 0;
        for (int i = 0; i < 3; i++) begin wd[i] = 8'h00; wt[i] = 0; end
        while (k < 3 && n < 40) begin
            @(negedge clk); n++;
            if (iocs && !iorw && ioaddr == 2'b00) begin wd[k] = databus; wt[k] = n; k++; end
        end
        check("rr_count", k, 3);
        check("rr_w0", wd[0], 8'hA0);
        check("rr_w1", wd[1], 8'hB1);
        check("rr_w2", wd[2], 8'hA0);
        check("rr_gap1", wt[1] - wt[0], 3);
        check("rr_gap2", wt[2] - wt[1], 3);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;

        step(); tbr = 1'b0; spart_rd = 8'h5A; rda = 1'b1; rx_ready = 1'b0;
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (iocs && iorw) k++;
        end
        check("rx_one_read", k, 1);
        check("rx_held_valid", rx_valid, 1);
        check("rx_held_data", rx_data, 8'h5A);
        step(); rx_ready = 1'b1;
        @(negedge clk);
        check("rx_valid_in_ready_cycle", rx_valid, 1);
        step(); rx_ready = 1'b0; rda = 1'b0;
        @(negedge clk);
        check("rx_cleared", rx_valid, 0);

`ifdef SPART_DRV_ECHO_EN
        step(); spart_rd = 8'h33; rda = 1'b1; req0_valid = 1'b1; req0_data = 8'h11; tbr = 1'b1;
        n = 0; k = 0; wd[0] = 8'h00; wd[1] = 8'h00;
        while (k < 2 && n < 40) begin
            @(negedge clk); n++;
            if (iocs && !iorw && ioaddr == 2'b00) begin wd[k] = databus; k++; end
        end
        check("echo_count", k, 2);
        check("echo_first", wd[0], 8'h33);
        check("echo_then_req0", wd[1], 8'h11);
        step(); req0_valid = 1'b0; rda = 1'b0; rx_ready = 1'b1;
        step(); rx_ready = 1'b0;
`endif

        step(); req0_valid = 1'b1; req0_data = 8'h77; tbr = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(iocs && !iorw && ioaddr == 2'b00) && n < 20) begin
            @(negedge clk); n++;
        end
        check("abort_found_wr", n < 20, 1);
        #1 rst = 1'b1; br_cfg = 2'b10; req0_valid = 1'b0;
        #1;
        check("abort_iocs", iocs, 0);
        check("abort_iorw", iorw, 1);
        check("abort_ready", req0_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_init("after_abort", 2'b10, 0);

        for (int c = 0; c < 3000; c++) begin
            step();
            if (seen_acc0) begin
                req0_valid = 1'($urandom_range(0, 1)); req0_data = 8'($urandom);
            end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1; req0_data = 8'($urandom);
            end
            if (seen_acc1) begin
                req1_valid = 1'($urandom_range(0, 1)); req1_data = 8'($urandom);
            end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1; req1_data = 8'($urandom);
            end
            if (seen_rd) rda = 1'b0;
            else if (!rda && $urandom_range(0, 4) == 0) begin
                rda = 1'b1; spart_rd = 8'($urandom);
            end
            if (seen_tx) begin
                tbr = 1'b0; tbr_wait = int'($urandom_range(0, 3));
            end else if (!tbr) begin
                if (tbr_wait == 0) tbr = 1'b1;
                else tbr_wait--;
            end
            rx_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 79) == 0) br_cfg = 2'($urandom_range(0, 3));
        end
        check("rand_tx_activity", tx_count > 50, 1);
        check("rand_rx_activity", rd_count > 50, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
